keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
//
// PURPOSE
//  Sequences the 4x4 matrix keypad: drives one column at a time, watches the
//  row inputs, debounces press and release, and emits exactly one key_valid
//  pulse with a 4-bit hex code per physical key press. Sits between the
//  keypad pins and the hex-digit shift register, replacing free-running
//  column logic with a scan/lock/debounce state machine.
//
// PARAMETERS
//  SCAN_DIV        100   clk cycles each column is driven before advancing (>=2)
//  DEBOUNCE_CYCLES 2000  consecutive stable clk cycles to accept press/release (>=2)
//
// PORTS
//  clk        in   1  system clock (divided clock from the clock divider)
//  reset      in   1  asynchronous, active-low reset
//  row        in   4  raw keypad rows, active-high (pull-downs), asynchronous
//  col        out  4  column drive, one-hot active-high
//  key        out  4  hex code of last accepted key; holds until next accept
//  key_valid  out  1  one-cycle pulse when key is updated
//
// BEHAVIOUR
//  - Reset (reset=0, async): col=4'b0001, key=4'h0, key_valid=0, state SCAN,
//    dwell/debounce counters 0, synchronizer flops 0.
//  - row passes a 2-flop synchronizer -> row_s; all decisions use row_s only.
//  - SCAN: dwell counter counts 0..SCAN_DIV-1 per column. On the dwell==SCAN_DIV-1
//    cycle: if row_s is exactly one-hot -> capture row_s as cap_row, hold col,
//    go DEBOUNCE; else rotate col 0001->0010->0100->1000->0001, dwell=0.
//    row_s zero or multi-hot is ignored (no capture).
//  - DEBOUNCE: col frozen. Count cycles with row_s==cap_row; at count
//    DEBOUNCE_CYCLES-1 -> HOLD. Any cycle with row_s!=cap_row -> SCAN, col
//    advances to next column, counters cleared, no pulse.
//  - Entering HOLD: key <= code(cap_row,col) and key_valid=1 on the first
//    HOLD cycle only (registered, exactly one cycle).
//  - HOLD: col frozen; stay while row_s!=0 (extra keys in the held column
//    ignored). row_s==0 -> RELEASE, counter cleared.
//  - RELEASE: count consecutive row_s==0 cycles; at DEBOUNCE_CYCLES-1 -> SCAN
//    with col advanced to next column. Any nonzero row_s -> back to HOLD,
//    no new key_valid (bounce on release never re-triggers).
//  - Key map (row r, col c), r0:1 2 3 A / r1:4 5 6 B / r2:7 8 9 C / r3:E 0 F D
//    (* = E, # = F).
//  - Holding a key indefinitely: one pulse only, scanning stays stopped.
//  - Reset asserted in any state returns to reset values immediately; after
//    release a still-held key is re-detected as a fresh press.
//  - Latency press->pulse (stable input, column already driven): 2 sync +
//    remaining dwell + DEBOUNCE_CYCLES + 1 cycles.
//  - Counters sized $clog2 of their parameter; no wrap beyond terminal count.
//
// TESTING  (bench uses SCAN_DIV=4, DEBOUNCE_CYCLES=8; row modelled as
//  row bit high only while matching col bit is driven)
//  1. Reset: hold reset=0 -> col=0001, key=0, key_valid=0; release, no key ->
//     col rotates every 4 cycles 0001,0010,0100,1000,0001.
//  2. Clean press r1c2 held 40 cycles -> exactly one key_valid, key=4'h6,
//     col frozen at 0100 until 8 cycles after release, then 1000.
//  3. Press-bounce: r3c1 toggled every 3 cycles for 30 cycles then stable ->
//     no pulse during bounce; one pulse with key=4'h0 after stable 8 cycles.
//  4. Release-bounce: after accepted r0c3 (key=A), row drops then reappears
//     for 2 cycles twice -> no second pulse; scanning resumes after 8 quiet.
//  5. Two keys r0c0+r2c0 pressed together -> multi-hot ignored, no pulse;
//     drop r2c0 -> single pulse key=4'h1.
//  6. Reset mid-HOLD on r2c3 (key=C): reset low 1 cycle -> key=0, col=0001;
//     key still held -> new pulse key=4'hC after scan reaches col 1000.

Source files
------------

// File: rtl/keypad_scan_if.sv
// Keypad pin bundle plus the accepted-key output toward the hex-digit shift register.
// master = scan controller, slave = keypad / downstream side.
interface keypad_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;

    modport master (
        input  row,
        output col,
        output key,
        output key_valid
    );

    modport slave (
        output row,
        input  col,
        input  key,
        input  key_valid
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-hot column drive, row synchronizer, press/release debounce,
// and a single key_valid pulse with the hex code per accepted key press.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 100,
    parameter int DEBOUNCE_CYCLES = 2000
) (
    input  logic          clk,
    input  logic          reset,
    keypad_scan_if.master kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

    state_t           state;
    logic [3:0]       row_p0;
    logic [3:0]       row_p1;
    logic [3:0]       cap_row;
    logic [3:0]       col_r;
    logic [3:0]       key_r;
    logic             kv_r;
    logic [DIV_W-1:0] dwell;
    logic [DEB_W-1:0] deb_cnt;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [3:0] next_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Keypad legend: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with * = E and # = F.
    function automatic logic [3:0] key_code(input logic [3:0] r, input logic [3:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({enc(r), enc(c)})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Stage p0/p1: two-flop synchronizer; row_p1 is the only row value the FSM looks at.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_p0 <= 4'b0000;
            row_p1 <= 4'b0000;
        end else begin
            row_p0 <= kp.row;
            row_p1 <= row_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == SCAN && dwell == DWELL_LAST && is_one_hot(row_p1)) begin
            cap_row <= row_p1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            col_r   <= 4'b0001;
            dwell   <= '0;
            deb_cnt <= '0;
            key_r   <= 4'h0;
            kv_r    <= 1'b0;
        end else begin
            kv_r <= 1'b0;
            case (state)
                SCAN: begin
                    deb_cnt <= '0;
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (is_one_hot(row_p1)) begin
                            state <= DEBOUNCE;
                        end else begin
                            col_r <= next_col(col_r);
                        end
                    end else begin
                        dwell <= dwell + DIV_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_p1 != cap_row) begin
                        state   <= SCAN;
                        col_r   <= next_col(col_r);
                        dwell   <= '0;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= HOLD;
                        key_r   <= key_code(cap_row, col_r);
                        kv_r    <= 1'b1;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                HOLD: begin
                    if (row_p1 == 4'b0000) begin
                        state   <= RELEASE;
                        deb_cnt <= '0;
                    end
                end
                RELEASE: begin
                    // A bounce back to nonzero rows returns to HOLD without a new pulse.
                    if (row_p1 != 4'b0000) begin
                        state <= HOLD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= SCAN;
                        col_r   <= next_col(col_r);
                        dwell   <= '0;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    assign kp.col       = col_r;
    assign kp.key       = key_r;
    assign kp.key_valid = kv_r;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: keypad matrix model, scoreboard of expected key
// pulses, and point checks of col/key/key_valid evaluated by the monitor.
module tb_keypad_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pressed [4];

    keypad_scan_if kp();

    keypad_scan_ctrl #(
        .SCAN_DIV       (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kp)
    );

    always #5 clk = ~clk;

    // A row reads high only while a pressed key sits in the driven column.
    always_comb begin
        kp.row = 4'b0000;
        for (int r = 0; r < 4; r++) kp.row[r] = |(pressed[r] & kp.col);
    end

    typedef struct {
        string      name;
        logic [3:0] col;
        logic [3:0] key;
        logic       kv;
    } chk_t;

    chk_t       chk_q [$];
    logic [3:0] exp_q [$];
    int         n_vec = 0;
    int         n_bad = 0;
    bit         fin_req = 1'b0;
    bit         done = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [3:0] c, input logic [3:0] k,
                              input logic v);
        chk_t t;
        t.name = nm;
        t.col  = c;
        t.key  = k;
        t.kv   = v;
        chk_q.push_back(t);
    endtask

    // Monitor: pops the expected key on every pulse, then evaluates pending point checks.
    initial begin
        chk_t       c;
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (kp.key_valid !== 1'b0) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pulse: key_valid=%b key=%h, required no pulse",
                             kp.key_valid, kp.key);
                end else begin
                    e = exp_q.pop_front();
                    if (kp.key !== e) begin
                        n_bad++;
                        $display("FAIL pulse_key: got key=%h, required %h", kp.key, e);
                    end
                end
            end
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_vec++;
                if (kp.col !== c.col || kp.key !== c.key || kp.key_valid !== c.kv) begin
                    n_bad++;
                    $display("FAIL %s: got col=%b key=%h kv=%b, required col=%b key=%h kv=%b",
                             c.name, kp.col, kp.key, kp.key_valid, c.col, c.key, c.kv);
                end
            end
            if (fin_req && !done) begin
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    n_bad++;
                    $display("FAIL missing_pulse: got no pulse, required key=%h", e);
                end
                done = 1'b1;
            end
        end
    end

    initial begin
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
        reset = 1'b0;

        // 1. reset values, then free rotation with no key
        tick(3);
        expect_now("reset_state", 4'b0001, 4'h0, 1'b0);
        tick(1);
        reset = 1'b1;
        tick(1);
        expect_now("rot_c0", 4'b0001, 4'h0, 1'b0);
        tick(4);
        expect_now("rot_c1", 4'b0010, 4'h0, 1'b0);
        tick(4);
        expect_now("rot_c2", 4'b0100, 4'h0, 1'b0);
        tick(4);
        expect_now("rot_c3", 4'b1000, 4'h0, 1'b0);
        tick(4);
        expect_now("rot_wrap", 4'b0001, 4'h0, 1'b0);

        // 2. clean press r1c2
        exp_q.push_back(4'h6);
        pressed[1][2] = 1'b1;
        tick(40);
        expect_now("t2_hold", 4'b0100, 4'h6, 1'b0);
        pressed[1][2] = 1'b0;
        tick(8);
        expect_now("t2_frozen", 4'b0100, 4'h6, 1'b0);
        tick(5);
        expect_now("t2_resume", 4'b1000, 4'h6, 1'b0);
        tick(10);

        // 3. press bounce on r3c1, then stable
        for (int i = 0; i < 10; i++) begin
            pressed[3][1] = ~pressed[3][1];
            tick(3);
        end
        exp_q.push_back(4'h0);
        pressed[3][1] = 1'b1;
        tick(40);
        expect_now("t3_hold", 4'b0010, 4'h0, 1'b0);
        pressed[3][1] = 1'b0;
        tick(20);

        // 4. release bounce on r0c3
        exp_q.push_back(4'hA);
        pressed[0][3] = 1'b1;
        tick(40);
        for (int i = 0; i < 2; i++) begin
            pressed[0][3] = 1'b0;
            tick(3);
            pressed[0][3] = 1'b1;
            tick(2);
        end
        pressed[0][3] = 1'b0;
        tick(13);
        expect_now("t4_resume", 4'b0001, 4'hA, 1'b0);
        tick(10);

        // 5. two keys in one column, then one released
        pressed[0][0] = 1'b1;
        pressed[2][0] = 1'b1;
        tick(40);
        exp_q.push_back(4'h1);
        pressed[2][0] = 1'b0;
        tick(40);
        expect_now("t5_hold", 4'b0001, 4'h1, 1'b0);
        pressed[0][0] = 1'b0;
        tick(20);

        // 6. reset during HOLD with the key still held
        exp_q.push_back(4'hC);
        pressed[2][3] = 1'b1;
        tick(40);
        expect_now("t6_hold", 4'b1000, 4'hC, 1'b0);
        tick(1);
        reset = 1'b0;
        expect_now("t6_reset", 4'b0001, 4'h0, 1'b0);
        tick(1);
        reset = 1'b1;
        exp_q.push_back(4'hC);
        tick(40);
        expect_now("t6_redetect", 4'b1000, 4'hC, 1'b0);
        pressed[2][3] = 1'b0;
        tick(20);

        fin_req = 1'b1;
        for (int i = 0; i < 10 && !done; i++) @(posedge clk);
        if (!done) begin
            $display("FAIL monitor_drain: got no completion, required completion within 10 cycles");
            $fatal(1, "monitor did not complete");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
